sram_access_master: RTL
=======================

SRAM_ACCESS_MASTER -- requirements
Module: sram_access_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, RAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM data width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  single clock; every flop on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH+2  byte address.
REQ-009 SHALL have port req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  load data valid; single-cycle pulse, no backpressure.
REQ-013 SHALL have port rsp_rdata  output  32  aligned, extended load data.
REQ-014 SHALL have port misaligned  output  1  single-cycle pulse one cycle after an illegal request is accepted.
REQ-015 SHALL have port ram_addr  output  ADDR_WIDTH  RAM word address.
REQ-016 SHALL have port ram_din  output  32  RAM write data.
REQ-017 SHALL have port ram_write_en  output  4  per-byte write enables; bit i covers bits 8i+7:8i.
REQ-018 SHALL have port ram_dout  input  32  RAM read data, valid one cycle after the address is presented.
REQ-019 SHALL have port init_done  output  1  high once the block accepts requests.

Function
REQ-020 ram_addr SHALL be driven combinationally: req_addr[ADDR_WIDTH+1:2] in RUN, the clear counter in CLEAR.
REQ-021 A store SHALL drive ram_din = req_wdata replicated per size and ram_write_en = 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half) or 1111 (word), all in the accept cycle.
REQ-022 ram_write_en SHALL be 0 unless a legal store is accepted in that cycle.
REQ-023 Illegal requests SHALL produce no write and no rsp_valid, and SHALL pulse misaligned one cycle later. Illegal means: size 3, half with addr[0]=1, or word with addr[1:0]!=0.
REQ-024 For a load, the block SHALL register addr[1:0], size and unsigned; the next cycle it SHALL assert rsp_valid with ram_dout shifted right by 8*addr[1:0] and then zero- or sign-extended. Load latency is 1 cycle.
REQ-025 Back-to-back loads and stores SHALL be accepted every cycle; the registered load metadata SHALL belong to the previous cycle's request only.
REQ-026 States SHALL be CLEAR and RUN. req_ready = (state==RUN). CLEAR -> RUN when the clear counter reaches 2^ADDR_WIDTH-1.

Reset
REQ-027 While reset_n is low: rsp_valid=0, rsp_rdata=0, misaligned=0, load metadata=0, clear counter=0.
REQ-028 While reset_n is low, state SHALL be CLEAR if SRAM_CLEAR_EN is defined, else RUN.
REQ-029 Reset asserted mid-operation SHALL drop any pending response; mid-clear reset SHALL restart the clear from word 0.

Configuration
REQ-030 With macro SRAM_CLEAR_EN defined, after reset the block SHALL write 0 with ram_write_en=1111 to words 0..2^ADDR_WIDTH-1, one per cycle, holding req_ready=0 and init_done=0. It SHALL then enter RUN and set init_done=1.
REQ-031 Without SRAM_CLEAR_EN: CLEAR state and counter absent, init_done tied 1, req_ready tied 1.

Structure
REQ-032 A shared package SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the state encodings.
REQ-033 Load alignment/extension SHALL be one combinational sub-module, load_data_align.

Verification
REQ-034 Word store addr 0x10, wdata 0xDEADBEEF -> ram_addr 4, ram_write_en 1111, ram_din 0xDEADBEEF.
REQ-035 Byte load addr 0x13, ram_dout 0x80FF_1234, signed -> next cycle rsp_valid=1, rsp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Half store addr 0x06, wdata 0x0000ABCD -> ram_write_en 1100, ram_din[31:16] 0xABCD; half load addr 0x05 -> no rsp_valid, misaligned pulse.
REQ-037 Loads at 0x0, 0x4, 0x8 in consecutive cycles -> three consecutive rsp_valid pulses, each matching its own request.
REQ-038 SRAM_CLEAR_EN, ADDR_WIDTH=4 -> 16 cycles of ram_write_en=1111, ram_din=0, then init_done=1; reset at cycle 8 restarts the clear at word 0.

Source files
------------

// File: rtl/sram_access_master_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_access_master_pkg : access-size and controller state encodings. Rev 1.0
// ---------------------------------------------------------------------------
package sram_access_master_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // A request is legal when its size is defined and it is naturally aligned.
  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: access_legal = 1'b1;
      SIZE_HALF: access_legal = ~off[0];
      SIZE_WORD: access_legal = (off == 2'b00);
      default:   access_legal = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_access_master_load_data_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_data_align : right-aligns RAM read data and zero/sign-extends it. Rev 1.0
// ---------------------------------------------------------------------------
module load_data_align
  import sram_access_master_pkg::*;
(
  input  logic [31:0] i_dout,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_shift;
  logic        w_sign_b;
  logic        w_sign_h;

  assign w_shift  = i_dout >> {i_offset, 3'b000};
  assign w_sign_b = ~i_unsigned & w_shift[7];
  assign w_sign_h = ~i_unsigned & w_shift[15];

  always_comb begin
    o_data = w_shift;
    case (i_size)
      SIZE_BYTE: o_data = {{24{w_sign_b}}, w_shift[7:0]};
      SIZE_HALF: o_data = {{16{w_sign_h}}, w_shift[15:0]};
      default:   o_data = w_shift;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sram_access_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_access_master : load/store front end for a 1-cycle-latency SRAM.
// Define SRAM_CLEAR_EN to zero the whole RAM after reset. Rev 1.0
// ---------------------------------------------------------------------------
module sram_access_master
  import sram_access_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    misaligned,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic [3:0]              ram_write_en,
  input  logic [DATA_WIDTH-1:0]   ram_dout,
  output logic                    init_done
);

  logic        w_run;
  logic        w_accept;
  logic        w_legal;
  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic [31:0] w_aligned;

  logic        r_rsp_valid;
  logic        r_misaligned;
  logic [1:0]  r_ld_off;
  logic [1:0]  r_ld_size;
  logic        r_ld_unsigned;

`ifdef SRAM_CLEAR_EN
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_init_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_CLEAR;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_cnt == {ADDR_WIDTH{1'b1}}) begin
        r_state     <= ST_RUN;
        r_init_done <= 1'b1;
      end else begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  assign w_run     = (r_state == ST_RUN);
  assign init_done = r_init_done;
`else
  assign w_run     = 1'b1;
  assign init_done = 1'b1;
`endif

  assign req_ready = w_run;
  assign w_accept  = req_valid & w_run;
  assign w_off     = req_addr[1:0];
  assign w_legal   = access_legal(req_size, w_off);

  always_comb begin
    case (req_size)
      SIZE_BYTE: begin
        w_mask  = 4'b0001 << w_off;
        w_wdata = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        w_mask  = 4'b0011 << w_off;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_mask  = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    ram_addr     = req_addr[ADDR_WIDTH+1:2];
    ram_din      = w_wdata;
    ram_write_en = (w_accept & req_we & w_legal) ? w_mask : 4'b0000;
`ifdef SRAM_CLEAR_EN
    if (!w_run) begin
      ram_addr     = r_clr_cnt;
      ram_din      = '0;
      ram_write_en = 4'b1111;
    end
`endif
  end

  // Metadata is captured every cycle so it only ever describes the previous request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid   <= 1'b0;
      r_misaligned  <= 1'b0;
      r_ld_off      <= 2'b00;
      r_ld_size     <= 2'b00;
      r_ld_unsigned <= 1'b0;
    end else begin
      r_rsp_valid   <= w_accept & ~req_we & w_legal;
      r_misaligned  <= w_accept & ~w_legal;
      r_ld_off      <= w_off;
      r_ld_size     <= req_size;
      r_ld_unsigned <= req_unsigned;
    end
  end

  load_data_align u_align (
    .i_dout     (ram_dout),
    .i_offset   (r_ld_off),
    .i_size     (r_ld_size),
    .i_unsigned (r_ld_unsigned),
    .o_data     (w_aligned)
  );

  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_valid ? w_aligned : '0;
  assign misaligned = r_misaligned;

endmodule
`default_nettype wire
